uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter; next generation of the fixed 8N1 TX block.
//  Serialises one character per valid/ready handshake onto a single line.
//  Configurable data width, parity, stop bits, bit order and baud divisor.
//  Sits between the byte source (FIFO/controller) and the TX pad.
// PARAMETERS
//  CLKS_PER_BIT  434  clocks per bit period, >=2 (434 = 50 MHz / 115200)
//  DATA_BITS     8    data bits per frame, 5..9
//  PARITY        0    0 = none, 1 = odd, 2 = even
//  STOP_BITS     1    1 or 2 stop bits
//  LSB_FIRST     1    1 = send TX_IN[0] first; 0 = send TX_IN[DATA_BITS-1] first
// PORTS
//  CLK       in   1          clock. One clock; reset is synchronous and active-high.
//  RST       in   1          synchronous active-high reset
//  TX_EN     in   1          enable; gates acceptance of new frames only
//  TX_VALID  in   1          TX_IN holds a character to send
//  TX_READY  out  1          block can accept (combinational: state==IDLE & ~RST)
//  TX_IN     in   DATA_BITS  character; captured on acceptance
//  OUT       out  1          serial line, idle high
//  BUSY      out  1          high from cycle after acceptance to end of last stop bit
//  DONE      out  1          one-cycle pulse on the first IDLE cycle after a frame
// BEHAVIOUR
//  - Reset: OUT=1, BUSY=0, DONE=0, state IDLE, counters 0, shift reg 0.
//  - Accept at posedge when TX_EN & TX_VALID & TX_READY; TX_IN and the computed
//    parity are latched; TX_IN ignored afterwards.
//  - FSM: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE.
//  - Each bit drives OUT for exactly CLKS_PER_BIT cycles; the START bit (OUT=0)
//    begins the cycle after acceptance. No extra wait before the start bit.
//  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT.
//  - Bit counter counts 0..DATA_BITS-1; clock counter width $clog2(CLKS_PER_BIT),
//    compare against CLKS_PER_BIT-1, wrap to 0.
//  - Parity: odd -> total ones (data+parity) odd; even -> total ones even.
//  - STOP: OUT=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE with DONE=1 for
//    one cycle. TX_READY is high in that same cycle: back-to-back frames get
//    exactly 1 idle-high clock between the last stop bit and the next start bit.
//  - TX_EN low mid-frame: current frame completes normally; no new accept.
//  - TX_VALID held without TX_EN: no accept, OUT stays 1.
//  - RST mid-frame: next cycle OUT=1, BUSY=0, DONE=0, IDLE; frame aborted,
//    no DONE pulse.
//  - OUT, BUSY and DONE are registered outputs (glitch-free line).
// TESTING
//  Use CLKS_PER_BIT=4 in simulation unless stated.
//  1 8N1 LSB-first, TX_IN=0xA5: OUT = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks.
//    40 clocks BUSY. DONE is 1 clock on cycle 41 after acceptance.
//  2 PARITY=2 (even), 0xA5: parity bit 0. PARITY=1 (odd), 0xA5: parity bit 1.
//    Frame is 44 clocks.
//  3 DATA_BITS=7, LSB_FIRST=0, STOP_BITS=2, TX_IN=7'h41: OUT = 0,1,0,0,0,0,0,1,1,1.
//    Frame is 40 clocks; the stop bits are high for 8 clocks.
//  4 Back-to-back: TX_VALID held high with 0x55 then 0x0F. Exactly 1 idle-high clock
//    between frames. TX_READY is low during both frames.
//  5 TX_EN dropped at clock 10 of a frame: frame finishes and DONE pulses.
//    A pending TX_VALID is not accepted until TX_EN rises again.
//  6 RST asserted at clock 15 of a 0x00 frame: next cycle OUT=1, BUSY=0.
//    No DONE pulse. A new frame is accepted normally afterwards.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: one character per valid/ready handshake,
// framed as start, DATA_BITS data, optional parity and 1-2 stop bits.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tx_en,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  input  logic [DATA_BITS-1:0] i_tx_in,
  output logic                 o_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2:0]           o_state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_out;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_par;
  logic [DATA_BITS-1:0] w_ordered;

  // Handshake: a character transfers on a rising clock where i_tx_en,
  // i_tx_valid and o_tx_ready are all high; o_tx_ready is high only in IDLE
  // outside reset and does not depend on i_tx_valid.
  assign o_tx_ready = (r_state == S_IDLE) & ~i_rst;
  assign w_accept   = i_tx_en & i_tx_valid & o_tx_ready;
  assign w_bit_end  = (r_clk_cnt == CNT_LAST);
  assign w_par      = (PARITY == 1) ? ~^i_tx_in : ^i_tx_in;

  // Store the character in transmit order so the shifter always emits bit 0.
  always_comb begin
    w_ordered = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      w_ordered[i] = (LSB_FIRST != 0) ? i_tx_in[i] : i_tx_in[DATA_BITS-1-i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_out     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_out <= 1'b1;
          if (w_accept) begin
            r_shift   <= w_ordered;
            r_par     <= w_par;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_out     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_out     <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              if (PARITY != 0) begin
                r_out   <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_out   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              r_out     <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_out     <= 1'b1;
            r_state   <= S_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == STOP_LAST) begin
              r_bit_cnt <= '0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_out   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_out   = r_out;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_state = r_state;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations, cycle-exact scoreboard of
// {ready, busy, done, out} per clock after each acceptance.
module tb_uart_tx_cfg;

  logic       clk;
  logic [3:0] rst;
  logic [3:0] tx_en;
  logic [3:0] tx_valid;
  logic [8:0] tx_in [4];
  logic [3:0] ready_w;
  logic [3:0] out_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;
  logic [2:0] state_w [4];

  int vectors;
  int miscompares;

  // Per-instance configuration used by the reference frame builder.
  int cfg_nb   [4] = '{8, 8, 8, 7};
  int cfg_par  [4] = '{0, 2, 1, 0};
  int cfg_stop [4] = '{1, 1, 1, 2};
  int cfg_lsb  [4] = '{1, 1, 1, 0};

  localparam int CPB = 4;

  logic [3:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .LSB_FIRST(1)) u_8n1 (
    .i_clk(clk), .i_rst(rst[0]), .i_tx_en(tx_en[0]), .i_tx_valid(tx_valid[0]),
    .o_tx_ready(ready_w[0]), .i_tx_in(tx_in[0][7:0]), .o_out(out_w[0]),
    .o_busy(busy_w[0]), .o_done(done_w[0]), .o_state(state_w[0]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .LSB_FIRST(1)) u_8e1 (
    .i_clk(clk), .i_rst(rst[1]), .i_tx_en(tx_en[1]), .i_tx_valid(tx_valid[1]),
    .o_tx_ready(ready_w[1]), .i_tx_in(tx_in[1][7:0]), .o_out(out_w[1]),
    .o_busy(busy_w[1]), .o_done(done_w[1]), .o_state(state_w[1]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .LSB_FIRST(1)) u_8o1 (
    .i_clk(clk), .i_rst(rst[2]), .i_tx_en(tx_en[2]), .i_tx_valid(tx_valid[2]),
    .o_tx_ready(ready_w[2]), .i_tx_in(tx_in[2][7:0]), .o_out(out_w[2]),
    .o_busy(busy_w[2]), .o_done(done_w[2]), .o_state(state_w[2]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .LSB_FIRST(0)) u_7n2 (
    .i_clk(clk), .i_rst(rst[3]), .i_tx_en(tx_en[3]), .i_tx_valid(tx_valid[3]),
    .o_tx_ready(ready_w[3]), .i_tx_in(tx_in[3][6:0]), .o_out(out_w[3]),
    .o_busy(busy_w[3]), .o_done(done_w[3]), .o_state(state_w[3]));

  // Line bits in transmit order, seq[n-1] first; each held CPB clocks, then the DONE cycle.
  task automatic push_bits(input logic [15:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      for (int c = 0; c < CPB; c++) exp_q.push_back({1'b0, 1'b1, 1'b0, seq[i]});
    end
    exp_q.push_back(4'b1011);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b1001);
  endtask

  task automatic push_frame(input int d, input logic [8:0] data);
    logic [15:0] seq;
    int n;
    int ones;
    int idx;
    seq = '0;
    n = 0;
    ones = 0;
    seq = {seq[14:0], 1'b0};
    n++;
    for (int i = 0; i < cfg_nb[d]; i++) begin
      idx = (cfg_lsb[d] != 0) ? i : cfg_nb[d] - 1 - i;
      seq = {seq[14:0], data[idx]};
      n++;
      if (data[idx]) ones++;
    end
    if (cfg_par[d] != 0) begin
      // Odd: total ones odd; even: total ones even.
      seq = {seq[14:0], (cfg_par[d] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1)};
      n++;
    end
    for (int s = 0; s < cfg_stop[d]; s++) begin
      seq = {seq[14:0], 1'b1};
      n++;
    end
    push_bits(seq, n);
  endtask

  task automatic send(input int d, input logic [8:0] data);
    @(posedge clk);
    #1;
    tx_in[d] = data;
    tx_en[d] = 1'b1;
    tx_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid[d] = 1'b0;
    tx_in[d] = 9'($urandom);
  endtask

  task automatic check_n(input int d, input int n, input string tag);
    logic [3:0] exp_v;
    logic [3:0] obs_v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs_v = {ready_w[d], busy_w[d], done_w[d], out_w[d]};
      vectors++;
      assert (obs_v === exp_v) else begin
        miscompares++;
        $error("FAIL %s dut%0d cyc%0d {rdy,busy,done,out} got %b want %b", tag, d, i + 1, obs_v, exp_v);
      end
    end
  endtask

  task automatic check_all(input int d, input string tag);
    check_n(d, exp_q.size(), tag);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 4'hF;
    tx_en = 4'h0;
    tx_valid = 4'h0;
    for (int i = 0; i < 4; i++) tx_in[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      vectors++;
      assert ({ready_w[d], busy_w[d], done_w[d], out_w[d], state_w[d]} === 7'b0001_000) else begin
        miscompares++;
        $error("FAIL reset dut%0d got %b want %b", d,
               {ready_w[d], busy_w[d], done_w[d], out_w[d], state_w[d]}, 7'b0001_000);
      end
    end
    @(posedge clk);
    #1;
    rst = 4'h0;
    for (int d = 0; d < 4; d++) begin
      push_idle(2);
      check_all(d, "post_reset_idle");
    end

    // 8N1 0xA5 against the literal line pattern.
    push_bits(16'b0101001011, 10);
    send(0, 9'h0A5);
    check_all(0, "8n1_a5");

    // Even and odd parity on 0xA5: parity bit 0 and 1 respectively.
    push_bits(16'b01010010101, 11);
    send(1, 9'h0A5);
    check_all(1, "even_a5");
    push_bits(16'b01010010111, 11);
    send(2, 9'h0A5);
    check_all(2, "odd_a5");

    // 7 data bits, MSB first, two stop bits.
    push_bits(16'b0100000111, 10);
    send(3, 9'h041);
    check_all(3, "7n2_msb_41");

    // Random characters through every configuration.
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 3; k++) begin
        logic [8:0] rv;
        rv = 9'($urandom_range(0, (1 << cfg_nb[d]) - 1));
        push_frame(d, rv);
        send(d, rv);
        check_all(d, "random_frame");
      end
    end

    // Back-to-back with TX_VALID held: one idle-high DONE clock between frames.
    push_frame(0, 9'h055);
    push_frame(0, 9'h00F);
    @(posedge clk);
    #1;
    tx_in[0] = 9'h055;
    tx_en[0] = 1'b1;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_in[0] = 9'h00F;
    check_n(0, 41, "b2b_first");
    @(posedge clk);
    #1;
    tx_valid[0] = 1'b0;
    check_all(0, "b2b_second");

    // TX_EN dropped at clock 10: frame completes, pending request waits.
    push_frame(0, 9'h03C);
    send(0, 9'h03C);
    check_n(0, 10, "en_drop_head");
    tx_en[0] = 1'b0;
    tx_valid[0] = 1'b1;
    tx_in[0] = 9'h0C3;
    check_all(0, "en_drop_tail");
    push_idle(6);
    check_all(0, "en_low_no_accept");
    push_frame(0, 9'h0C3);
    tx_en[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid[0] = 1'b0;
    check_all(0, "en_restored_frame");

    // Reset at clock 15 of a 0x00 frame: line idles at once, no DONE ever.
    push_frame(0, 9'h000);
    send(0, 9'h000);
    check_n(0, 15, "rst_head");
    exp_q.delete();
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    push_idle(45);
    check_all(0, "rst_abort_idle");
    push_frame(0, 9'h096);
    send(0, 9'h096);
    check_all(0, "after_rst_frame");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
